// File: rtl/picobello_uart_dbg_responder.sv
// UART debug responder: decodes host WRITE/READ frames into 64-bit memory requests and replies with data + ACK/NAK.
// Optional inter-byte timeout abort is compiled in with `define UART_DBG_TIMEOUT_EN.
module picobello_uart_dbg_responder #(
  parameter int unsigned AddrWidth     = 48,
  parameter int unsigned TimeoutCycles = 65536
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [7:0]           rx_data_i,
  input  logic                 rx_valid_i,
  output logic                 rx_ready_o,
  output logic [7:0]           tx_data_o,
  output logic                 tx_valid_o,
  input  logic                 tx_ready_i,
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [63:0]          mem_wdata_o,
  output logic [7:0]           mem_strb_o,
  input  logic                 mem_rvalid_i,
  input  logic [63:0]          mem_rdata_i,
  input  logic                 mem_err_i,
  output logic                 busy_o
);

  typedef enum logic [3:0] {
    IDLE, ADDR, LEN, WDATA, WREQ, WRSP, RREQ, RRSP, RDATA, STAT
  } state_e;

  localparam logic [7:0] CmdWrite = 8'h01;
  localparam logic [7:0] CmdRead  = 8'h02;
  localparam logic [7:0] Ack      = 8'h06;
  localparam logic [7:0] Nak      = 8'h15;

  state_e                 state_q, state_d;
  logic [2:0]             byte_cnt_q;
  logic [7:0]             word_cnt_q;
  logic [AddrWidth-1:3]   addr_q;
  logic [63:0]            data_q;
  logic                   is_write_q, err_q, active_q;
  logic                   rx_fire, tx_fire, rsp_fire, word_done, last_word, timeout;

  assign rx_fire   = rx_valid_i && rx_ready_o;
  assign tx_fire   = tx_valid_o && tx_ready_i;
  // A response counts in the grant cycle too, so single-cycle memories skip the RSP states.
  assign rsp_fire  = mem_rvalid_i && ((((state_q == WREQ) || (state_q == RREQ)) && mem_gnt_i)
                                      || (state_q == WRSP) || (state_q == RRSP));
  assign last_word = (word_cnt_q == 8'd0);
  assign word_done = (rsp_fire && ((state_q == WREQ) || (state_q == WRSP)))
                  || (tx_fire && (state_q == RDATA) && (byte_cnt_q == 3'd7));

`ifdef UART_DBG_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);
  logic [TmoW-1:0] tmo_cnt_q;
  logic            waiting;

  assign waiting = (state_q == ADDR) || (state_q == LEN) || (state_q == WDATA);
  assign timeout = waiting && !rx_fire && (tmo_cnt_q == TmoW'(TimeoutCycles - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt_q <= '0;
    end else if (!waiting || rx_fire) begin
      tmo_cnt_q <= '0;
    end else if (!timeout) begin
      tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (rx_fire) state_d = ((rx_data_i == CmdWrite) || (rx_data_i == CmdRead)) ? ADDR : STAT;
      ADDR:  if (rx_fire && (byte_cnt_q == 3'd7)) state_d = LEN;
      LEN:   if (rx_fire) state_d = is_write_q ? WDATA : RREQ;
      WDATA: if (rx_fire && (byte_cnt_q == 3'd7)) state_d = WREQ;
      WREQ:  if (mem_gnt_i) state_d = mem_rvalid_i ? (last_word ? STAT : WDATA) : WRSP;
      WRSP:  if (mem_rvalid_i) state_d = last_word ? STAT : WDATA;
      RREQ:  if (mem_gnt_i) state_d = mem_rvalid_i ? RDATA : RRSP;
      RRSP:  if (mem_rvalid_i) state_d = RDATA;
      RDATA: if (tx_fire && (byte_cnt_q == 3'd7)) state_d = last_word ? STAT : RREQ;
      STAT:  if (tx_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (timeout) state_d = STAT;
  end

  always_comb begin
    rx_ready_o = 1'b0;
    tx_valid_o = 1'b0;
    tx_data_o  = 8'h00;
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    unique case (state_q)
      IDLE, ADDR, LEN, WDATA: rx_ready_o = active_q;
      WREQ: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
      end
      RREQ:  mem_req_o = 1'b1;
      RDATA: begin
        tx_valid_o = 1'b1;
        tx_data_o  = data_q[{byte_cnt_q, 3'b000} +: 8];
      end
      STAT: begin
        tx_valid_o = 1'b1;
        tx_data_o  = err_q ? Nak : Ack;
      end
      default: ;
    endcase
  end

  assign busy_o      = (state_q != IDLE);
  assign mem_addr_o  = {addr_q, 3'b000};
  assign mem_wdata_o = data_q;
  assign mem_strb_o  = 8'hFF;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q   <= 1'b0;
      byte_cnt_q <= 3'd0;
      word_cnt_q <= 8'd0;
      addr_q     <= '0;
      data_q     <= 64'd0;
      is_write_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      active_q <= 1'b1;
      if (state_q == IDLE) begin
        byte_cnt_q <= 3'd0;
      end else if ((rx_fire && ((state_q == ADDR) || (state_q == WDATA)))
                   || (tx_fire && (state_q == RDATA))) begin
        byte_cnt_q <= byte_cnt_q + 3'd1;
      end
      if ((state_q == IDLE) && rx_fire) begin
        is_write_q <= (rx_data_i == CmdWrite);
        err_q      <= !((rx_data_i == CmdWrite) || (rx_data_i == CmdRead));
      end else if (timeout || (rsp_fire && mem_err_i)) begin
        err_q <= 1'b1;
      end
      // Address bytes arrive LSB first; bits above AddrWidth and below bit 3 are dropped.
      if ((state_q == ADDR) && rx_fire) begin
        for (int i = 3; i < int'(AddrWidth); i++) begin
          if (byte_cnt_q == 3'(i / 8)) addr_q[i] <= rx_data_i[3'(i % 8)];
        end
      end
      if ((state_q == LEN) && rx_fire) word_cnt_q <= rx_data_i;
      if ((state_q == WDATA) && rx_fire) data_q[{byte_cnt_q, 3'b000} +: 8] <= rx_data_i;
      if (rsp_fire && ((state_q == RREQ) || (state_q == RRSP))) data_q <= mem_rdata_i;
      if (word_done && !last_word) begin
        word_cnt_q <= word_cnt_q - 8'd1;
        addr_q     <= addr_q + (AddrWidth - 3)'(1);
      end
    end
  end

endmodule

// File: tb/tb_picobello_uart_dbg_responder.sv
// Scoreboard bench for picobello_uart_dbg_responder: directed frames, queued expectations, negedge monitors.
module tb_picobello_uart_dbg_responder;

  localparam int AW = 48;
`ifdef UART_DBG_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 65536;
`endif

  logic          clk, rst_n;
  logic [7:0]    rx_data, tx_data, mem_strb;
  logic          rx_valid, rx_ready, tx_valid, tx_ready;
  logic          mem_req, mem_gnt, mem_we, mem_rvalid, mem_err, busy;
  logic [AW-1:0] mem_addr;
  logic [63:0]   mem_wdata, mem_rdata;

  picobello_uart_dbg_responder #(.AddrWidth(AW), .TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_strb_o(mem_strb),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .mem_err_i(mem_err),
    .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic we; logic [AW-1:0] addr; logic [63:0] wdata; } mem_exp_t;
  typedef struct { logic [63:0] rdata; logic err; int gdly; bit late; } mem_rsp_t;

  mem_exp_t   exp_mem[$];
  mem_rsp_t   rsp_q[$];
  logic [7:0] exp_tx[$];
  int         checks = 0;
  int         errors = 0;
  bit         tx_rand = 0;
  mem_rsp_t   cur;
  bit         pend = 0;
  int         wcnt = 0;
  mem_exp_t   mon_e;
  logic [7:0] mon_b;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      tx_ready = tx_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Memory model: grant after a per-transaction delay, respond in the grant cycle or one later.
  initial begin
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0; mem_err = 0;
    forever begin
      @(posedge clk); #1;
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0; mem_err = 0;
      if (pend) begin
        mem_rvalid = 1; mem_rdata = cur.rdata; mem_err = cur.err; pend = 0;
      end else if (mem_req && rst_n) begin
        if (wcnt < ((rsp_q.size() > 0) ? rsp_q[0].gdly : 0)) begin
          wcnt++;
        end else begin
          cur = (rsp_q.size() > 0) ? rsp_q.pop_front() : '{64'd0, 1'b0, 0, 1'b0};
          wcnt = 0;
          mem_gnt = 1;
          if (cur.late) pend = 1;
          else begin mem_rvalid = 1; mem_rdata = cur.rdata; mem_err = cur.err; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && mem_req && mem_gnt) begin
      if (exp_mem.size() == 0) begin
        checks++; errors++;
        $display("FAIL mem_unexpected: got request addr %h we %b, required none", mem_addr, mem_we);
      end else begin
        mon_e = exp_mem.pop_front();
        chk("mem_we", 64'(mem_we), 64'(mon_e.we));
        chk("mem_addr", 64'(mem_addr), 64'(mon_e.addr));
        if (mon_e.we) begin
          chk("mem_wdata", mem_wdata, mon_e.wdata);
          chk("mem_strb", 64'(mem_strb), 64'hFF);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready) begin
      if (exp_tx.size() == 0) begin
        checks++; errors++;
        $display("FAIL tx_unexpected: got byte %h, required none", tx_data);
      end else begin
        mon_b = exp_tx.pop_front();
        chk("tx_byte", 64'(tx_data), 64'(mon_b));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bit hs = 0;
    rx_valid = 1; rx_data = b;
    while (!hs && n < 1000) begin
      @(negedge clk); hs = rx_ready;
      @(posedge clk); #1;
      n++;
    end
    rx_valid = 0; rx_data = 8'h00;
    if (!hs) begin
      checks++; errors++;
      $display("FAIL rx_accept: byte %h not accepted, required acceptance within 1000 cycles", b);
    end
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [63:0] addr, input logic [7:0] len);
    send_byte(cmd);
    for (int i = 0; i < 8; i++) send_byte(addr[8*i +: 8]);
    send_byte(len);
  endtask

  task automatic send_word(input logic [63:0] w);
    for (int i = 0; i < 8; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic push_tx_word(input logic [63:0] w);
    for (int i = 0; i < 8; i++) exp_tx.push_back(w[8*i +: 8]);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (n < 5000 && !(exp_tx.size() == 0 && !busy)) begin
      @(negedge clk); n++;
    end
    @(posedge clk); #1;
    chk({name, "_pending_tx"}, 64'(exp_tx.size()), 64'd0);
    chk({name, "_pending_mem"}, 64'(exp_mem.size()), 64'd0);
    chk({name, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_rx_ready"}, 64'(rx_ready), 64'd0);
    chk({name, "_tx_valid"}, 64'(tx_valid), 64'd0);
    chk({name, "_tx_data"}, 64'(tx_data), 64'd0);
    chk({name, "_mem_req"}, 64'(mem_req), 64'd0);
    chk({name, "_mem_we"}, 64'(mem_we), 64'd0);
    chk({name, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({name, "_mem_wdata"}, mem_wdata, 64'd0);
    chk({name, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required completion within 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; rx_valid = 0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1; rst_n = 1;
    @(posedge clk); @(negedge clk);
    chk("rx_ready_after_reset", 64'(rx_ready), 64'd1);
    @(posedge clk); #1;

    // Single-word write
    exp_mem.push_back('{1'b1, 48'h0000_8000_0000, 64'h1122334455667788});
    rsp_q.push_back('{64'd0, 1'b0, 0, 1'b0});
    exp_tx.push_back(8'h06);
    send_hdr(8'h01, 64'h8000_0000, 8'h00);
    send_word(64'h1122334455667788);
    @(negedge clk);
    chk("write_req_latency", 64'(mem_req), 64'd1);
    @(posedge clk); #1;
    wait_idle("write1");

    // Two-word read, second response one cycle after grant
    exp_mem.push_back('{1'b0, 48'h0000_8000_0008, 64'd0});
    exp_mem.push_back('{1'b0, 48'h0000_8000_0010, 64'd0});
    rsp_q.push_back('{64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 0, 1'b0});
    rsp_q.push_back('{64'hBBBB_BBBB_BBBB_BBBB, 1'b0, 1, 1'b1});
    push_tx_word(64'hAAAA_AAAA_AAAA_AAAA);
    push_tx_word(64'hBBBB_BBBB_BBBB_BBBB);
    exp_tx.push_back(8'h06);
    send_hdr(8'h02, 64'h8000_0008, 8'h01);
    wait_idle("read2");

    // Bad command, then a two-word write that wraps the 48-bit address
    exp_tx.push_back(8'h15);
    exp_tx.push_back(8'h06);
    exp_mem.push_back('{1'b1, 48'hFFFF_FFFF_FFF8, 64'hDEADBEEF_00000001});
    exp_mem.push_back('{1'b1, 48'h0000_0000_0000, 64'hCAFEF00D_12345678});
    rsp_q.push_back('{64'd0, 1'b0, 2, 1'b1});
    rsp_q.push_back('{64'd0, 1'b0, 0, 1'b0});
    send_byte(8'h7F);
    send_hdr(8'h01, 64'h0000_FFFF_FFFF_FFF8, 8'h01);
    send_word(64'hDEADBEEF_00000001);
    send_word(64'hCAFEF00D_12345678);
    wait_idle("badcmd_wrap");

    // Read with error response, unaligned address with upper garbage, random tx backpressure
    tx_rand = 1;
    exp_mem.push_back('{1'b0, 48'h0000_0000_0100, 64'd0});
    rsp_q.push_back('{64'h0123456789ABCDEF, 1'b1, 1, 1'b1});
    push_tx_word(64'h0123456789ABCDEF);
    exp_tx.push_back(8'h15);
    send_hdr(8'h02, 64'hCDAB_0000_0000_0107, 8'h00);
    wait_idle("read_err");
    tx_rand = 0;

    // Reset in the middle of write data; nothing may come out
    send_hdr(8'h01, 64'h8000_0000, 8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    rst_n = 0;
    @(negedge clk);
    chk_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1; rst_n = 1;
    exp_mem.push_back('{1'b1, 48'h0000_0000_0040, 64'h0807060504030201});
    rsp_q.push_back('{64'd0, 1'b0, 0, 1'b1});
    exp_tx.push_back(8'h06);
    send_hdr(8'h01, 64'h40, 8'h00);
    send_word(64'h0807060504030201);
    wait_idle("post_reset_write");

`ifdef UART_DBG_TIMEOUT_EN
    // Stall after three address bytes
    exp_tx.push_back(8'h15);
    send_byte(8'h01);
    send_byte(8'hF0); send_byte(8'h00); send_byte(8'h00);
    wait_idle("timeout");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
